// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that scans a low-resolution framebuffer out to the DAC,
// replicating each framebuffer word 2**SCALE_SHIFT times in both axes.
module vga_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FB_W        = 160,
    parameter int unsigned FB_H        = 120,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic        fb_rd_en,
    output logic [7:0]  fb_rd_x,
    output logic [7:0]  fb_rd_y,
    input  logic [11:0] fb_rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned L       = RD_LATENCY;
    // Each delay stage holds {hs, vs, visible}; syncs idle high.
    localparam logic [L-1:0][2:0] PIPE_RST = {L{3'b110}};

    logic [9:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [7:0]        x, y, fb_rd_x_q, fb_rd_x_d, fb_rd_y_q, fb_rd_y_d;
    logic              h_wrap, v_wrap, active, inrange, hs_raw, vs_raw;
    logic              fb_rd_en_q, fb_rd_en_d, vblank_q, vblank_d;
    logic              frame_start_q, frame_start_d;
    logic              vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
    logic [11:0]       rgb_q, rgb_d;
    logic [L-1:0][2:0] pipe_q, pipe_d;

    always_comb begin
        h_wrap  = h_cnt_q == 10'(H_TOTAL - 1);
        v_wrap  = v_cnt_q == 10'(V_TOTAL - 1);
        x       = 8'(h_cnt_q >> SCALE_SHIFT);
        y       = 8'(v_cnt_q >> SCALE_SHIFT);
        active  = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
        inrange = ({1'b0, x} < 9'(FB_W)) && ({1'b0, y} < 9'(FB_H));
        hs_raw  = !((h_cnt_q >= 10'(H_ACTIVE + H_FP)) && (h_cnt_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw  = !((v_cnt_q >= 10'(V_ACTIVE + V_FP)) && (v_cnt_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
        h_cnt_d       = pix_en ? (h_wrap ? 10'd0 : h_cnt_q + 10'd1) : h_cnt_q;
        v_cnt_d       = (pix_en && h_wrap) ? (v_wrap ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
        fb_rd_x_d     = pix_en ? x : fb_rd_x_q;
        fb_rd_y_d     = pix_en ? y : fb_rd_y_q;
        fb_rd_en_d    = pix_en && active && inrange;
        vblank_d      = pix_en ? (v_cnt_q >= 10'(V_ACTIVE)) : vblank_q;
        frame_start_d = pix_en && h_wrap && v_wrap;
        pipe_d = pipe_q;
        if (pix_en) begin
            pipe_d[0] = {hs_raw, vs_raw, active && inrange};
            for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];
        end
        // The read issued L ticks ago has its data on fb_rd_data now.
        vga_hs_d = pix_en ? pipe_q[L-1][2] : vga_hs_q;
        vga_vs_d = pix_en ? pipe_q[L-1][1] : vga_vs_q;
        rgb_d    = pix_en ? (pipe_q[L-1][0] ? fb_rd_data : 12'h000) : rgb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            fb_rd_x_q     <= '0;
            fb_rd_y_q     <= '0;
            fb_rd_en_q    <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
            pipe_q        <= PIPE_RST;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            rgb_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            fb_rd_x_q     <= fb_rd_x_d;
            fb_rd_y_q     <= fb_rd_y_d;
            fb_rd_en_q    <= fb_rd_en_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
            pipe_q        <= pipe_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            rgb_q         <= rgb_d;
        end
    end

    assign fb_rd_en    = fb_rd_en_q;
    assign fb_rd_x     = fb_rd_x_q;
    assign fb_rd_y     = fb_rd_y_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule
